// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised raster timing generator. Produces horizontal and
//                vertical position counters, blanking, sync, display enable,
//                and line/frame start strobes for any video mode set by
//                parameters. A pixel-enable input lets the generator run from
//                a clock faster than the pixel rate.
//  Optional    : define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt
//                output, which counts completed frames.
//  Ports       :
//      pclk        in   1      pixel clock, rising edge
//      reset_n     in   1      asynchronous reset, active-low
//      ce          in   1      pixel enable; counters advance only when 1
//      restart     in   1      synchronous jump to (0,0), ignores ce
//      hcount      out  CNT_W  horizontal position 0..H_TOTAL-1
//      vcount      out  CNT_W  vertical position 0..V_TOTAL-1
//      hblnk       out  1      horizontal blanking
//      vblnk       out  1      vertical blanking
//      hsync       out  1      horizontal sync (asserted level H_POL)
//      vsync       out  1      vertical sync (asserted level V_POL)
//      de          out  1      display enable (not blanked)
//      line_start  out  1      high while hcount == 0
//      frame_start out  1      high while hcount == 0 and vcount == 0
//      frame_cnt   out  16     completed-frame counter (optional)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   CNT_W    = 11,
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             restart,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_ZERO     = '0;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    // Sync windows are held as first/last inclusive positions so the upper
    // bound always fits in CNT_W bits, even when a back porch of zero puts
    // the exclusive end at H_TOTAL == 2**CNT_W.
    localparam logic [CNT_W-1:0] c_HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------------
    generate
        if (CNT_W < 1 || CNT_W > 30) begin : g_err_cnt_w
            $error("vga_timing_gen: CNT_W must be in 1..30");
        end
        if (H_ACTIVE < 1 || H_SYNC < 1 || H_FP < 0 || H_BP < 0) begin : g_err_h_param
            $error("vga_timing_gen: illegal horizontal timing parameters");
        end
        if (V_ACTIVE < 1 || V_SYNC < 1 || V_FP < 0 || V_BP < 0) begin : g_err_v_param
            $error("vga_timing_gen: illegal vertical timing parameters");
        end
        if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_err_h_window
            $error("vga_timing_gen: hsync window extends beyond H_TOTAL");
        end
        if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_err_v_window
            $error("vga_timing_gen: vsync window extends beyond V_TOTAL");
        end
        if ((H_TOTAL - 1) >= (1 << CNT_W)) begin : g_err_h_width
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL");
        end
        if ((V_TOTAL - 1) >= (1 << CNT_W)) begin : g_err_v_width
            $error("vga_timing_gen: CNT_W too narrow for V_TOTAL");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_line_start;
    logic             r_frame_start;

    // ------------------------------------------------------------------------
    // Next-position logic
    // ------------------------------------------------------------------------
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_load;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;

    assign w_h_wrap = (r_hcount == c_H_LAST);
    assign w_v_wrap = (r_vcount == c_V_LAST);

    always_comb begin
        w_load   = 1'b0;
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (restart) begin
            // restart outranks both ce and any wrap in progress
            w_load   = 1'b1;
            w_h_next = c_ZERO;
            w_v_next = c_ZERO;
        end else if (ce) begin
            w_load = 1'b1;
            if (w_h_wrap) begin
                w_h_next = c_ZERO;
                w_v_next = w_v_wrap ? c_ZERO : (r_vcount + c_ONE);
            end else begin
                w_h_next = r_hcount + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flag decode from the next position, so every registered flag lines up
    // with the counter value it describes.
    // ------------------------------------------------------------------------
    logic w_hblnk;
    logic w_vblnk;
    logic w_hs_win;
    logic w_vs_win;
    logic w_hsync;
    logic w_vsync;
    logic w_de;
    logic w_line_start;
    logic w_frame_start;

    always_comb begin
        w_hblnk       = (w_h_next >= c_H_ACT);
        w_vblnk       = (w_v_next >= c_V_ACT);
        w_hs_win      = (w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST);
        w_vs_win      = (w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST);
        w_hsync       = w_hs_win ? H_POL : ~H_POL;
        w_vsync       = w_vs_win ? V_POL : ~V_POL;
        w_de          = ~w_hblnk & ~w_vblnk;
        w_line_start  = (w_h_next == c_ZERO);
        w_frame_start = w_line_start && (w_v_next == c_ZERO);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= c_ZERO;
            r_vcount      <= c_ZERO;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_de          <= 1'b1;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else if (w_load) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hblnk       <= w_hblnk;
            r_vblnk       <= w_vblnk;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_de          <= w_de;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // ------------------------------------------------------------------------
    // Frame counter: steps only on a natural end-of-frame wrap, never on
    // restart, so software can tell forced resyncs from real frames.
    // ------------------------------------------------------------------------
    logic [15:0] r_frame_cnt;
    logic        w_frame_wrap;

    assign w_frame_wrap = ce & ~restart & w_h_wrap & w_v_wrap;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 16'h0000;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Three instances run
//                side by side (default 1344x806, 640x480 negative-sync, and a
//                tiny 16x8 mode so whole frames fit in a short run) against a
//                behavioural reference model feeding an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hb, vb, hs, vs, de, ls, fs;
    } out_t;

    typedef struct packed {
        out_t [2:0]        o;
        logic [2:0] [15:0] f;
    } exp_t;

    typedef struct {
        logic alt;
        logic c;
        logic r;
        int   n;
        int   exp_h;
        int   exp_v;
    } vec_t;

    // Per-instance timing: 0 = defaults, 1 = 640x480, 2 = tiny
    localparam int HA[3] = '{1024, 640, 8};
    localparam int HF[3] = '{24,   16,  2};
    localparam int HS[3] = '{136,  96,  3};
    localparam int HB[3] = '{160,  48,  3};
    localparam int VA[3] = '{768,  480, 4};
    localparam int VF[3] = '{3,    10,  1};
    localparam int VS[3] = '{6,    2,   2};
    localparam int VB[3] = '{29,   33,  1};
    localparam int HP[3] = '{1,    0,   0};
    localparam int VP[3] = '{1,    0,   0};

    logic pclk    = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b0;
    logic restart = 1'b0;

    logic [10:0] h0, v0;
    logic [9:0]  h1, v1;
    logic [4:0]  h2, v2;
    logic hb0, vb0, hs0, vs0, de0, ls0, fs0;
    logic hb1, vb1, hs1, vs1, de1, ls1, fs1;
    logic hb2, vb2, hs2, vs2, de2, ls2, fs2;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] f0, f1, f2;
`endif

    always #5 pclk = ~pclk;

    vga_timing_gen dut0 (
        .pclk(pclk), .reset_n(reset_n), .ce(ce), .restart(restart),
        .hcount(h0), .vcount(v0), .hblnk(hb0), .vblnk(vb0), .hsync(hs0),
        .vsync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(f0)
`endif
    );

    vga_timing_gen #(
        .CNT_W(10), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut1 (
        .pclk(pclk), .reset_n(reset_n), .ce(ce), .restart(restart),
        .hcount(h1), .vcount(v1), .hblnk(hb1), .vblnk(vb1), .hsync(hs1),
        .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(f1)
`endif
    );

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut2 (
        .pclk(pclk), .reset_n(reset_n), .ce(ce), .restart(restart),
        .hcount(h2), .vcount(v2), .hblnk(hb2), .vblnk(vb2), .hsync(hs2),
        .vsync(vs2), .de(de2), .line_start(ls2), .frame_start(fs2)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(f2)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          mh[3];
    int          mv[3];
    logic [15:0] mf[3];
    exp_t        q[$];

    function automatic out_t act(int k);
        out_t o;
        case (k)
            0:       o = {h0, v0, hb0, vb0, hs0, vs0, de0, ls0, fs0};
            1:       o = {1'b0, h1, 1'b0, v1, hb1, vb1, hs1, vs1, de1, ls1, fs1};
            default: o = {6'b0, h2, 6'b0, v2, hb2, vb2, hs2, vs2, de2, ls2, fs2};
        endcase
        return o;
    endfunction

`ifdef VGA_TIMING_FRAME_CNT_EN
    function automatic logic [15:0] act_f(int k);
        case (k)
            0:       return f0;
            1:       return f1;
            default: return f2;
        endcase
    endfunction
`endif

    // Reference decode straight from the timing definitions
    function automatic out_t model_out(int k);
        out_t o;
        logic hp, vp, hwin, vwin;
        hp   = (HP[k] != 0);
        vp   = (VP[k] != 0);
        hwin = (mh[k] >= HA[k] + HF[k]) && (mh[k] < HA[k] + HF[k] + HS[k]);
        vwin = (mv[k] >= VA[k] + VF[k]) && (mv[k] < VA[k] + VF[k] + VS[k]);
        o.h  = 11'(mh[k]);
        o.v  = 11'(mv[k]);
        o.hb = (mh[k] >= HA[k]);
        o.vb = (mv[k] >= VA[k]);
        o.hs = hwin ? hp : ~hp;
        o.vs = vwin ? vp : ~vp;
        o.de = !o.hb && !o.vb;
        o.ls = (mh[k] == 0);
        o.fs = (mh[k] == 0) && (mv[k] == 0);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mh[k] = 0;
            mv[k] = 0;
            mf[k] = 16'h0;
        end
    endtask

    task automatic model_step(input logic c, input logic r);
        int ht, vt;
        for (int k = 0; k < 3; k++) begin
            ht = HA[k] + HF[k] + HS[k] + HB[k];
            vt = VA[k] + VF[k] + VS[k] + VB[k];
            if (r) begin
                mh[k] = 0;
                mv[k] = 0;
            end else if (c) begin
                if (mh[k] == ht - 1) begin
                    mh[k] = 0;
                    if (mv[k] == vt - 1) begin
                        mv[k] = 0;
                        mf[k] = mf[k] + 16'h1;
                    end else begin
                        mv[k] = mv[k] + 1;
                    end
                end else begin
                    mh[k] = mh[k] + 1;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.o[k] = model_out(k);
            e.f[k] = mf[k];
        end
        q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing to compare, required one entry", tag);
            return;
        end
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act(k) !== e.o[k]) begin
                errors++;
                $display("FAIL %s dut%0d: got %h required %h (t=%0t)", tag, k, act(k), e.o[k], $time);
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (act_f(k) !== e.f[k]) begin
                errors++;
                $display("FAIL %s dut%0d frame_cnt: got %0d required %0d", tag, k, act_f(k), e.f[k]);
            end
`endif
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // One pclk cycle: drive, predict, then compare just after the edge
    task automatic cycle(input logic c, input logic r);
        ce      = c;
        restart = r;
        model_step(c, r);
        push_exp();
        @(posedge pclk);
        #1;
        check_outputs("cycle");
    endtask

    vec_t tbl[5];

    initial begin
        int n0, first0, hb_rise, n1, first1;
        logic [15:0] fsave;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1400, 56,  1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 40,   76,  1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 10,   76,  1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1,    0,   0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 2000, 656, 1};

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        model_reset();
        push_exp();
        check_outputs("reset");
        reset_n = 1'b1;
        cycle(1'b0, 1'b0);

        // Table-driven segments, end position of the default instance checked
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                cycle(tbl[t].alt ? ((i % 2) == 0) : tbl[t].c, tbl[t].r);
            end
            chk($sformatf("table%0d hcount", t), int'(h0), tbl[t].exp_h);
            chk($sformatf("table%0d vcount", t), int'(v0), tbl[t].exp_v);
        end

        // Sync and blank edges across one full default line
        cycle(1'b0, 1'b1);
        n0 = 0; first0 = -1; hb_rise = -1; n1 = 0; first1 = -1;
        for (int i = 0; i < 1344; i++) begin
            cycle(1'b1, 1'b0);
            if (hs0) begin
                n0++;
                if (first0 < 0) first0 = int'(h0);
            end
            if (hb0 && hb_rise < 0) hb_rise = int'(h0);
            if (v1 == 10'd0 && !hs1) begin
                n1++;
                if (first1 < 0) first1 = int'(h1);
            end
        end
        chk("hsync width default", n0, 136);
        chk("hsync first default", first0, 1048);
        chk("hblnk rise default", hb_rise, 1024);
        chk("hsync width 640", n1, 96);
        chk("hsync first 640", first1, 656);

        // Restart exactly at the last position of the tiny mode
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 127; i++) cycle(1'b1, 1'b0);
        chk("tiny at last h", int'(h2), 15);
        chk("tiny at last v", int'(v2), 7);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fsave = f2;
`else
        fsave = 16'h0;
`endif
        cycle(1'b1, 1'b1);
        chk("restart wrap h", int'(h2), 0);
        chk("restart wrap v", int'(v2), 0);
        chk("restart wrap fs", int'(fs2), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("restart keeps frame_cnt", int'(f2), int'(fsave));
`endif
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        chk("restart ce0 h", int'(h0), 0);

        // Asynchronous reset mid-line, no clock edge involved
        for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0);
        chk("pre-reset hcount", int'(h0), 500);
        ce = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        check_outputs("async_reset");
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("post-reset first count", int'(h0), 1);

        // Three whole frames of the tiny mode from reset-start
        cycle(1'b0, 1'b1);
        ce = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 384; i++) cycle(1'b1, 1'b0);
        chk("tiny frame back at fs", int'(fs2), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt after 3 frames", int'(f2), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
